// File: rtl/quad_pkg.sv
// Shared state encoding, direction constants and Gray-code successor for the
// quadrature step decoder.
package quad_pkg;

    localparam logic [1:0] Q_S0 = 2'b00;
    localparam logic [1:0] Q_S1 = 2'b01;
    localparam logic [1:0] Q_S2 = 2'b11;
    localparam logic [1:0] Q_S3 = 2'b10;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] state);
        logic [1:0] nxt;
        case (state)
            Q_S0:    nxt = Q_S1;
            Q_S1:    nxt = Q_S2;
            Q_S2:    nxt = Q_S3;
            default: nxt = Q_S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_debounce_ch.sv
// One quadrature channel: synchroniser chain followed by a consecutive-cycle
// debouncer. While load is high the settled value tracks the synchroniser.
module quad_debounce_ch #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic load,
    output logic settled
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync    <= '0;
            cnt     <= '0;
            settled <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (load) begin
                settled <= synced;
                cnt     <= '0;
            end else if (synced == settled) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Last of the required consecutive differing cycles.
                settled <= ~settled;
                cnt     <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: debounced channels, Gray-code step decode producing a
// one-cycle enable with direction, and an error pulse on double transitions.
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic qa,
    input  logic qb,
    output logic e,
    output logic x,
    output logic err,
    output logic armed
);

    localparam int ARM_EDGES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int ARM_W     = $clog2(ARM_EDGES);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_EDGES - 1);

    logic             a_settled;
    logic             b_settled;
    logic             load;
    logic [1:0]       cur;
    logic [1:0]       prev;
    logic [ARM_W-1:0] arm_cnt;
    logic             same;
    logic             step_up;
    logic             step_dn;

    assign load = ~armed;

    quad_debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ch_a (
        .clk    (clk),
        .rst    (rst),
        .raw    (qa),
        .load   (load),
        .settled(a_settled)
    );

    quad_debounce_ch #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_ch_b (
        .clk    (clk),
        .rst    (rst),
        .raw    (qb),
        .load   (load),
        .settled(b_settled)
    );

    always_comb begin
        cur     = {a_settled, b_settled};
        same    = (cur == prev);
        step_up = (cur == next_fwd(prev));
        step_dn = (prev == next_fwd(cur));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
            prev    <= Q_S0;
            e       <= 1'b0;
            x       <= DIR_DN;
            err     <= 1'b0;
        end else if (!armed) begin
            e   <= 1'b0;
            err <= 1'b0;
            // Settling window: prev is taken from whatever the inputs settled to,
            // so a non-zero start position does not look like a step.
            if (arm_cnt == ARM_LAST) begin
                armed <= 1'b1;
                prev  <= cur;
            end else begin
                arm_cnt <= arm_cnt + ARM_W'(1);
            end
        end else begin
            prev <= cur;
            e    <= step_up | step_dn;
            err  <= ~(same | step_up | step_dn);
            if (step_up) begin
                x <= DIR_UP;
            end else if (step_dn) begin
                x <= DIR_DN;
            end
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Scoreboard bench for quad_step_decoder: directed quadrature sequences push
// expected pulses; a monitor matches every e/err pulse against the queue.
module tb_quad_step_decoder;

    localparam int LAT = 6;
    localparam int K_E = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int kind;
        int xv;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic qa = 1'b1;
    logic qb = 1'b1;
    logic e, x, err, armed;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  exp_q[$];
    ev_t  mon_ev;
    int   act_kind;

    quad_step_decoder dut (
        .clk  (clk),
        .rst  (rst),
        .qa   (qa),
        .qb   (qb),
        .e    (e),
        .x    (x),
        .err  (err),
        .armed(armed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every e/err pulse must match the head of the queue.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
            mon_ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: kind %0d expected at cycle %0d, still absent at cycle %0d",
                     mon_ev.kind, mon_ev.cyc, cyc);
        end
        if (e || err) begin
            act_kind = e ? (err ? 3 : K_E) : K_ERR;
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", act_kind, 0);
            end else begin
                mon_ev = exp_q.pop_front();
                check("pulse_kind", act_kind, mon_ev.kind);
                check("pulse_cycle", cyc, mon_ev.cyc);
                check("pulse_x", int'(x), mon_ev.xv);
            end
        end
    end

    // Called at a falling edge: drive inputs, hold for 'hold' rising edges.
    task automatic apply(input logic a, input logic b, input int hold,
                         input int kind, input int xv);
        ev_t ev;
        qa = a;
        qb = b;
        if (kind != 0) begin
            ev.kind = kind;
            ev.xv   = xv;
            ev.cyc  = cyc + 1 + LAT;
            exp_q.push_back(ev);
        end
        repeat (hold) @(negedge clk);
    endtask

    // Called at a falling edge: async reset for one rising edge, then check arming.
    task automatic reset_arm(input logic a, input logic b);
        qa = a;
        qb = b;
        #2 rst = 1'b0;
        #1;
        check("rst_e", int'(e), 0);
        check("rst_x", int'(x), 0);
        check("rst_err", int'(err), 0);
        check("rst_armed", int'(armed), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check($sformatf("armed_edge%0d", i), int'(armed), (i >= 6) ? 1 : 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Arm with inputs at 11: no pulses at all.
        reset_arm(1'b1, 1'b1);
        repeat (20) @(negedge clk);

        // Arm from 00, forward sequence.
        reset_arm(1'b0, 1'b0);
        apply(1'b0, 1'b1, 20, K_E, 1);
        apply(1'b1, 1'b1, 20, K_E, 1);
        apply(1'b1, 1'b0, 20, K_E, 1);
        apply(1'b0, 1'b0, 20, K_E, 1);

        // Reverse sequence.
        apply(1'b1, 1'b0, 20, K_E, 0);
        apply(1'b1, 1'b1, 20, K_E, 0);
        apply(1'b0, 1'b1, 20, K_E, 0);
        apply(1'b0, 1'b0, 20, K_E, 0);
        check("x_after_reverse", int'(x), 0);

        // Three-cycle glitch on qa is rejected.
        apply(1'b1, 1'b0, 3, 0, 0);
        apply(1'b0, 1'b0, 20, 0, 0);

        // Double transition 00->11 errors, x unchanged; then forward steps.
        apply(1'b1, 1'b1, 20, K_ERR, 0);
        apply(1'b1, 1'b0, 20, K_E, 1);
        apply(1'b0, 1'b0, 20, K_E, 1);
        apply(1'b0, 1'b1, 20, K_E, 1);
        apply(1'b1, 1'b1, 20, K_E, 1);
        check("x_before_reset", int'(x), 1);
        check("queue_drained_pre_reset", exp_q.size(), 0);

        // Mid-operation reset with settled = 11: re-arms without a pulse.
        reset_arm(1'b1, 1'b1);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_empty_at_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
